// File: rtl/min_max_ctrl.sv
// Sequencing controller for the min/max LED bar display: lamp test on reset or request,
// then run mode where inc/dec pulses move the value inside a loadable [min,max] range.
module min_max_ctrl #(
  parameter int VALSIZE     = 4,
  parameter int OSC_DIV     = 4,
  parameter int TEST_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               mode_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               cfg_load_i,
  input  logic [VALSIZE-1:0] min_i,
  input  logic [VALSIZE-1:0] max_i,
  input  logic               test_start_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o,
  output logic               busy_o,
  output logic               cfg_err_o
);

  localparam int PW = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;
  localparam int OW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(TEST_CYCLES - 1);
  localparam logic [OW-1:0] OSC_LAST   = OW'(OSC_DIV - 1);

  typedef enum logic [1:0] {TEST_OFF, TEST_ON, RUN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic [OW-1:0] osc_cnt;
  logic [1:0]    com_nxt;
  logic          busy_nxt;
  logic          cfg_ok;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= TEST_OFF;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    case (state)
      TEST_OFF: begin
        if (phase_cnt == PHASE_LAST) begin
          state_nxt = TEST_ON;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      TEST_ON: begin
        if (phase_cnt == PHASE_LAST) begin
          state_nxt = RUN;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      RUN: begin
        if (test_start_i) begin
          state_nxt = TEST_OFF;
          phase_nxt = '0;
        end
      end
      default: begin
        state_nxt = TEST_OFF;
        phase_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    com_nxt  = 2'b10;
    busy_nxt = 1'b1;
    case (state_nxt)
      TEST_OFF: com_nxt = 2'b10;
      TEST_ON:  com_nxt = 2'b11;
      RUN: begin
        com_nxt  = {1'b0, mode_i};
        busy_nxt = 1'b0;
      end
      default: com_nxt = 2'b10;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      com_o  <= 2'b10;
      busy_o <= 1'b1;
    end else begin
      com_o  <= com_nxt;
      busy_o <= busy_nxt;
    end
  end

  // The divider only runs on edges that both start and end in RUN, so the entry edge counts as zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      osc_o   <= 1'b1;
      osc_cnt <= '0;
    end else if (state == RUN && state_nxt == RUN) begin
      if (osc_cnt == OSC_LAST) begin
        osc_o   <= ~osc_o;
        osc_cnt <= '0;
      end else begin
        osc_cnt <= osc_cnt + 1'b1;
      end
    end else begin
      osc_o   <= 1'b1;
      osc_cnt <= '0;
    end
  end

  assign cfg_ok = (min_i <= max_i);

  // A configuration load, valid or not, swallows any inc/dec in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      min_o     <= '0;
      max_o     <= '1;
      val_o     <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= 1'b0;
      if (cfg_load_i) begin
        if (cfg_ok) begin
          min_o <= min_i;
          max_o <= max_i;
          if (val_o < min_i)
            val_o <= min_i;
          else if (val_o > max_i)
            val_o <= max_i;
        end else begin
          cfg_err_o <= 1'b1;
        end
      end else if (state == RUN) begin
        if (inc_i && !dec_i && (val_o < max_o))
          val_o <= val_o + 1'b1;
        else if (dec_i && !inc_i && (val_o > min_o))
          val_o <= val_o - 1'b1;
      end
    end
  end

endmodule

// File: doc/min_max_ctrl.md
Name: min_max_ctrl

Overview:
- Sequencing controller for the min/max LED bar display datapath.
- Owns the display command (com), range bounds (min/max), current value and the blink oscillator (osci); drives them as registered outputs straight into the display datapath.
- Runs a lamp-test sequence (all OFF, then all ON) at reset and on request, then enters run mode. In run mode, user increment/decrement pulses move the value inside the configured range.

Parameters:
- VALSIZE, 4, width of min/max/value; the display has 2**VALSIZE LEDs.
- OSC_DIV, 4, clock cycles per osc half-period (>=1).
- TEST_CYCLES, 8, clock cycles spent in each lamp-test phase (>=1).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous reset, active low.
- mode_i  in  1  run display mode: 0 normal, 1 linear.
- inc_i  in  1  one-cycle request: value +1.
- dec_i  in  1  one-cycle request: value -1.
- cfg_load_i  in  1  one-cycle request: load min_i/max_i.
- min_i  in  VALSIZE  requested lower bound.
- max_i  in  VALSIZE  requested upper bound.
- test_start_i  in  1  one-cycle request: restart lamp test.
- com_o  out  2  display command: 00 normal, 01 linear, 10 all off, 11 all on.
- min_o  out  VALSIZE  active lower bound.
- max_o  out  VALSIZE  active upper bound.
- val_o  out  VALSIZE  current value.
- osc_o  out  1  blink signal for LEDs between value and max.
- busy_o  out  1  lamp test in progress.
- cfg_err_o  out  1  one-cycle pulse: configuration load rejected.

Behaviour:
- All outputs are registered. Asynchronous reset (rst_n_i=0) forces, immediately:
  - state TEST_OFF, phase counter 0;
  - com_o=10, min_o=0, max_o=2**VALSIZE-1, val_o=0;
  - osc_o=1, busy_o=1, cfg_err_o=0.
- FSM states:
  - TEST_OFF: com_o=10, busy_o=1. Stays exactly TEST_CYCLES rising edges after reset release, then goes to TEST_ON with the counter cleared.
  - TEST_ON: com_o=11, busy_o=1. Stays TEST_CYCLES edges, then goes to RUN.
  - RUN: busy_o=0, com_o={0,mode_i} sampled one cycle earlier (one-cycle latency).
  - test_start_i=1 in RUN goes to TEST_OFF on the next edge. It is ignored in the TEST states; the sequence is not restarted.
- osc:
  - Held at 1 outside RUN, with its divider counter at 0.
  - In RUN, osc_o toggles every OSC_DIV cycles. The first toggle happens OSC_DIV cycles after the RUN entry edge. Period is 2*OSC_DIV cycles.
- Value update, RUN only (inc/dec ignored while busy_o=1):
  - inc_i only: val_o <= val_o+1 if val_o<max_o, else unchanged (saturate, no wrap).
  - dec_i only: val_o <= val_o-1 if val_o>min_o, else unchanged.
  - inc_i and dec_i together: no change.
- Configuration load (cfg_load_i=1), accepted in any state:
  - If min_i<=max_i: min_o<=min_i, max_o<=max_i, and val_o is clamped into the new range on the same edge: below min gives min_i, above max gives max_i.
  - If min_i>max_i: bounds and value unchanged, cfg_err_o=1 for exactly one cycle.
  - min_i==max_i is legal.
  - A load in the same cycle as inc/dec takes priority; inc/dec is dropped that cycle.
- Range rules:
  - Comparisons are unsigned over VALSIZE bits; no arithmetic wider than VALSIZE is exposed.
  - At reset, val_o (0) equals min_o, so the invariant min_o<=val_o<=max_o holds at all times.
- Reset asserted mid-sequence or in RUN aborts immediately to the reset values above.

Test Plan:
- Reset release, VALSIZE=4, TEST_CYCLES=8:
  - com_o=10 for 8 cycles, then 11 for 8 cycles, then RUN with com_o=00 (mode_i=0); busy_o falls on RUN entry.
  - osc_o=1 until 4 cycles into RUN (OSC_DIV=4), then toggles every 4 cycles.
- In RUN, load min=3,max=12 with val_o=0:
  - val_o=3 next cycle.
  - 9 inc pulses give val_o=12; a 10th inc pulse keeps 12.
  - dec pulses back to 3; a further dec keeps 3.
- Load min=9,max=5:
  - cfg_err_o high for exactly 1 cycle; min_o/max_o/val_o unchanged.
  - Then load min=2,max=6 with val_o=12: val_o=6.
- inc_i and dec_i both high with val_o=5: val_o stays 5.
  - inc_i and cfg_load_i (min=0,max=15) together: bounds load, val_o unchanged.
- mode_i=1 in RUN: com_o=01 one cycle later.
  - test_start_i pulse: full 10/11 sequence again, inc pulses ignored meanwhile, val_o preserved across it.
- rst_n_i low mid-TEST_ON and mid-RUN: outputs immediately at reset values; sequence restarts from TEST_OFF after release.
